// File: rtl/truth_table_seq.sv
// Truth-table sequencer/checker: sweeps all 2^N_IN input vectors of a function unit,
// samples its output after SETTLE cycles per vector and compares against a latched table.
module truth_table_seq #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected,
    input  logic                  f_in,
    output logic [N_IN-1:0]       vec,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(1<<N_IN)-1:0]  table_out,
    output logic [N_IN:0]         mismatch_cnt,
    output logic [N_IN-1:0]       first_fail,
    output logic                  fail_valid
);

    localparam int unsigned TW = 1 << N_IN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [3:0]      scnt, scnt_n;
    logic [TW-1:0]   exp_l, exp_l_n;
    logic [N_IN-1:0] vec_n;
    logic            busy_n, pass_n, fail_valid_n;
    logic [TW-1:0]   table_n;
    logic [N_IN:0]   mismatch_cnt_n;
    logic [N_IN-1:0] first_fail_n;
    logic            miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            scnt         <= '0;
            exp_l        <= '0;
            vec          <= '0;
            busy         <= 1'b0;
            pass         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
        end else begin
            state        <= state_n;
            scnt         <= scnt_n;
            exp_l        <= exp_l_n;
            vec          <= vec_n;
            busy         <= busy_n;
            pass         <= pass_n;
            table_out    <= table_n;
            mismatch_cnt <= mismatch_cnt_n;
            first_fail   <= first_fail_n;
            fail_valid   <= fail_valid_n;
        end
    end

    always_comb begin
        state_n        = state;
        scnt_n         = scnt;
        exp_l_n        = exp_l;
        vec_n          = vec;
        busy_n         = busy;
        pass_n         = pass;
        table_n        = table_out;
        mismatch_cnt_n = mismatch_cnt;
        first_fail_n   = first_fail;
        fail_valid_n   = fail_valid;
        miss           = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    vec_n          = '0;
                    exp_l_n        = expected;
                    table_n        = '0;
                    mismatch_cnt_n = '0;
                    first_fail_n   = '0;
                    fail_valid_n   = 1'b0;
                    pass_n         = 1'b0;
                    busy_n         = 1'b1;
                    scnt_n         = '0;
                    state_n        = S_WAIT;
                end
            end
            S_WAIT: begin
                scnt_n = scnt + 4'd1;
                if (scnt == 4'(SETTLE - 1)) state_n = S_SAMPLE;
            end
            S_SAMPLE: begin
                table_n[vec] = f_in;
                miss         = (f_in != exp_l[vec]);
                if (miss) begin
                    mismatch_cnt_n = mismatch_cnt + 1'b1;
                    if (!fail_valid) begin
                        first_fail_n = vec;
                        fail_valid_n = 1'b1;
                    end
                end
                // pass must include the mismatch (if any) on this final vector
                if (vec == N_IN'(TW - 1)) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    pass_n  = (mismatch_cnt_n == '0);
                end else begin
                    vec_n   = vec + 1'b1;
                    scnt_n  = '0;
                    state_n = S_WAIT;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign done = (state == S_DONE);

endmodule

// File: tb/tb_truth_table_seq.sv
// Bench for truth_table_seq driving a modelled f = a & b unit; final results are
// scoreboarded per run and checked when done pulses.
module tb_truth_table_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic [3:0]  vec;
    logic        busy, done, pass, fail_valid;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        glitch;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  mcnt;
        logic [3:0]  ff;
        logic        fv;
        logic        pass;
    } res_t;

    res_t sb[$];
    int   n_cmp, n_err;

    truth_table_seq #(.N_IN(4), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f_in),
        .vec(vec), .busy(busy), .done(done), .pass(pass), .table_out(table_out),
        .mismatch_cnt(mismatch_cnt), .first_fail(first_fail), .fail_valid(fail_valid)
    );

    // Unit under test: f = a & b, optionally corrupted outside the sampling cycle
    assign f_in = (vec[3] & vec[2]) ^ glitch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] e);
        res_t r;
        logic t;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            t = (k >= 12);
            r.tbl[k] = t;
            if (t != e[k]) begin
                if (!r.fv) begin
                    r.ff = k[3:0];
                    r.fv = 1'b1;
                end
                r.mcnt = r.mcnt + 5'd1;
            end
        end
        r.pass = (r.mcnt == 5'd0);
        return r;
    endfunction

    // One full run; start accepted at edge 0, observations taken #1 after each edge
    task automatic do_run(input logic [15:0] e, input bit extra, input bit glitchy,
                          output int done_edge, output int pulses, output int busy_bad,
                          output int vec_bad, output res_t obs);
        logic [3:0] vexp;
        done_edge = -1; pulses = 0; busy_bad = 0; vec_bad = 0; obs = '0;
        expected = e;
        start = 1'b1;
        sb.push_back(model(e));
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            vexp = (k < 48) ? 4'(k / 3) : 4'd15;
            if (busy !== (k < 48)) busy_bad++;
            if (vec !== vexp) vec_bad++;
            if (done === 1'b1) begin
                pulses++;
                if (done_edge < 0) begin
                    done_edge = k;
                    obs = '{table_out, mismatch_cnt, first_fail, fail_valid, pass};
                end
            end
            glitch = glitchy && (k < 48) && (k % 3 != 2);
            if (extra) begin
                if (k == 9)  begin start = 1'b1; expected = ~e; end
                if (k == 10) start = 1'b0;
                if (k == 47) start = 1'b1;
                if (k == 48) start = 1'b0;
            end
            @(posedge clk); #1;
        end
        glitch = 1'b0;
        start  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; expected = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({vec, busy, done, pass, table_out, mismatch_cnt, first_fail, fail_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_values: vec=%h busy=%b done=%b pass=%b tbl=%h mcnt=%0d ff=%0d fv=%b, required all 0",
                     vec, busy, done, pass, table_out, mismatch_cnt, first_fail, fail_valid);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_run(input string name, input logic [15:0] e, input bit extra, input bit glitchy);
        int de, pu, bb, vb;
        res_t obs, ex;
        do_run(e, extra, glitchy, de, pu, bb, vb, obs);
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL %s_scoreboard: queue empty, required 1 entry", name);
            return;
        end
        ex = sb.pop_front();
        n_cmp++; if (de !== 48) begin n_err++; $display("FAIL %s_done_edge: got %0d required 48", name, de); end
        n_cmp++; if (pu !== 1) begin n_err++; $display("FAIL %s_done_pulses: got %0d required 1", name, pu); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL %s_busy_window: %0d bad cycles required 0", name, bb); end
        n_cmp++; if (vb !== 0) begin n_err++; $display("FAIL %s_vec_sequence: %0d bad cycles required 0", name, vb); end
        n_cmp++; if (obs.tbl !== ex.tbl) begin n_err++; $display("FAIL %s_table: got %h required %h", name, obs.tbl, ex.tbl); end
        n_cmp++; if (obs.mcnt !== ex.mcnt) begin n_err++; $display("FAIL %s_mcnt: got %0d required %0d", name, obs.mcnt, ex.mcnt); end
        n_cmp++; if (obs.ff !== ex.ff) begin n_err++; $display("FAIL %s_first_fail: got %0d required %0d", name, obs.ff, ex.ff); end
        n_cmp++; if (obs.fv !== ex.fv) begin n_err++; $display("FAIL %s_fail_valid: got %b required %b", name, obs.fv, ex.fv); end
        n_cmp++; if (obs.pass !== ex.pass) begin n_err++; $display("FAIL %s_pass: got %b required %b", name, obs.pass, ex.pass); end
        n_cmp++; if (pass !== ex.pass) begin n_err++; $display("FAIL %s_pass_hold: got %b required %b", name, pass, ex.pass); end
    endtask

    task automatic test_mid_reset;
        int pu;
        expected = 16'hF000;
        start = 1'b1;
        sb.push_back(model(16'hF000));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        n_cmp++;
        if ({vec, busy, done, pass, table_out, mismatch_cnt, first_fail, fail_valid} !== '0) begin
            n_err++;
            $display("FAIL midreset_values: vec=%h busy=%b done=%b pass=%b tbl=%h mcnt=%0d ff=%0d fv=%b, required all 0",
                     vec, busy, done, pass, table_out, mismatch_cnt, first_fail, fail_valid);
        end
        pu = 0;
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1 || busy === 1'b1) pu++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pu !== 0) begin n_err++; $display("FAIL midreset_no_done: %0d active cycles required 0", pu); end
        test_run("after_reset", 16'hF000, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; expected = '0; glitch = 1'b0;
        test_reset();
        test_run("pass", 16'hF000, 1'b0, 1'b0);
        test_run("two_miss", 16'hF000 ^ 16'h0420, 1'b0, 1'b0);
        test_run("all_miss", 16'h0FFF, 1'b0, 1'b0);
        test_run("extra_start", 16'hF000 ^ 16'h8001, 1'b1, 1'b0);
        test_mid_reset();
        test_run("sample_point", 16'hF000, 1'b0, 1'b1);
        test_run("back_to_back", 16'h1234, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
